ifetch_buffer: RTL

//   Fetch stage directly downstream of the PC register. Takes the current pc,

---
 rtl/ifetch_buffer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/ifetch_buffer.sv
// ---------------------------------------------------------------------------
// ifetch_buffer
//   Fetch stage that sits directly after the PC register. It accepts a pc,
//   reads one instruction word from instruction memory over a req/ack
//   handshake, and queues {pc, instruction} pairs for decode in a DEPTH-entry
//   FIFO. Only one memory read is outstanding at a time. A FIFO slot is
//   reserved when a pc is accepted, so the queue can never overflow. A flush
//   (branch/jump redirect) empties the queue and discards any read in flight.
//
// Ports
//   clk_i         clock, rising edge
//   rst_ni        asynchronous reset, active low
//   pc_i          fetch address from the PC register
//   pc_valid_i    pc_i holds a valid fetch address this cycle
//   pc_ready_o    pc_i is accepted this cycle; the PC may advance (comb)
//   flush_i       discard the queue and any in-flight fetch
//   imem_req_o    memory read request (from the state register)
//   imem_addr_o   word-aligned read address, held stable until ack
//   imem_ack_i    read data valid this cycle
//   imem_rdata_i  read data, sampled when imem_ack_i=1
//   inst_valid_o  FIFO holds at least one entry
//   inst_ready_i  decode consumes the head entry
//   inst_o        head instruction, 0 when the FIFO is empty
//   inst_pc_o     pc of the head instruction, 0 when the FIFO is empty
//   fifo_count_o  current FIFO occupancy
// ---------------------------------------------------------------------------
module ifetch_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [ADDR_W-1:0]          pc_i,
  input  logic                       pc_valid_i,
  output logic                       pc_ready_o,
  input  logic                       flush_i,
  output logic                       imem_req_o,
  output logic [ADDR_W-1:0]          imem_addr_o,
  input  logic                       imem_ack_i,
  input  logic [DATA_W-1:0]          imem_rdata_i,
  output logic                       inst_valid_o,
  input  logic                       inst_ready_i,
  output logic [DATA_W-1:0]          inst_o,
  output logic [ADDR_W-1:0]          inst_pc_o,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W+1)'(DEPTH);
  localparam logic [CNT_W:0]   ONE_EXT   = (CNT_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  // IDLE: no fetch; BUSY: fetch live; DROP: fetch live but its data is unwanted
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   req_pc_q, req_pc_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   mem_inst_q [DEPTH];
  logic [ADDR_W-1:0]   mem_pc_q   [DEPTH];

  logic                nonempty_s;
  logic                pop_s;
  logic                push_s;
  logic                busy_ack_s;
  logic                space_s;
  logic                accept_s;
  logic [CNT_W:0]      occ_after_s;

  // Handshake decode: pop, push, free-space and accept conditions
  always_comb begin
    nonempty_s  = (count_q != {CNT_W{1'b0}});
    pop_s       = nonempty_s & inst_ready_i & ~flush_i;
    busy_ack_s  = (state_q == ST_BUSY) & imem_ack_i;
    push_s      = busy_ack_s & ~flush_i;
    // Occupancy once the returning word lands and any pop retires; the new
    // pc needs a slot beyond that.
    occ_after_s = {1'b0, count_q} + ONE_EXT - {{CNT_W{1'b0}}, pop_s};
    if (state_q == ST_IDLE) begin
      space_s = (count_q < DEPTH_CNT);
    end else if (busy_ack_s) begin
      space_s = (occ_after_s < DEPTH_EXT);
    end else begin
      space_s = 1'b0;
    end
    accept_s = pc_valid_i & ~flush_i & space_s &
               ((state_q == ST_IDLE) | busy_ack_s);
  end

  // Fetch state machine next-state logic and request address capture
  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    if (accept_s) begin
      req_pc_d = pc_i;
    end else begin
      req_pc_d = req_pc_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (flush_i) begin
          // An ack coinciding with the flush closes the fetch outright.
          state_d = imem_ack_i ? ST_IDLE : ST_DROP;
        end else if (imem_ack_i) begin
          state_d = accept_s ? ST_BUSY : ST_IDLE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DROP: begin
        if (imem_ack_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO pointer and occupancy next-state; flush overrides push and pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      count_d  = count_q + {{(CNT_W-1){1'b0}}, push_s}
                         - {{(CNT_W-1){1'b0}}, pop_s};
    end
  end

  // Control state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      req_pc_q <= {ADDR_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage, written at the write pointer on each push
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst_q[i] <= {DATA_W{1'b0}};
        mem_pc_q[i]   <= {ADDR_W{1'b0}};
      end
    end else if (push_s) begin
      mem_inst_q[wr_ptr_q] <= imem_rdata_i;
      mem_pc_q[wr_ptr_q]   <= req_pc_q;
    end
  end

  // Output drive: memory side from the state register, decode side from the head entry
  always_comb begin
    pc_ready_o   = accept_s;
    imem_req_o   = (state_q == ST_BUSY) | (state_q == ST_DROP);
    imem_addr_o  = {req_pc_q[ADDR_W-1:2], 2'b00};
    inst_valid_o = nonempty_s;
    fifo_count_o = count_q;
    if (nonempty_s) begin
      inst_o    = mem_inst_q[rd_ptr_q];
      inst_pc_o = mem_pc_q[rd_ptr_q];
    end else begin
      inst_o    = {DATA_W{1'b0}};
      inst_pc_o = {ADDR_W{1'b0}};
    end
  end

endmodule
